// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port, byte-maskable memory between an instruction-fetch
// port (I) and a load/store port (D), returning one-cycle-latency read data to the owner.
module mem_port_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic [31:0] mem_addr,
    output logic        mem_rstrb,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    logic        last_d_q, last_d_d;
    logic        rv_i_q, rv_i_d;
    logic        rv_d_q, rv_d_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        i_win, d_win;

    // Winner selection; no grant may issue while reset is held.
    always_comb begin
        i_win = 1'b0;
        d_win = 1'b0;
        if (!reset) begin
            if (i_req && d_req) begin
                if (RR_EN && last_d_q) begin
                    i_win = 1'b1;
                end else begin
                    d_win = 1'b1;
                end
            end else if (i_req) begin
                i_win = 1'b1;
            end else if (d_req) begin
                d_win = 1'b1;
            end
        end
    end

    // Memory drive; address and write data hold their last value when idle.
    always_comb begin
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        mem_rstrb = 1'b0;
        mem_wmask = 4'b0000;
        last_d_d  = last_d_q;
        if (i_win) begin
            mem_addr  = i_addr;
            mem_rstrb = 1'b1;
            last_d_d  = 1'b0;
        end else if (d_win) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_wmask = d_wmask;
            mem_rstrb = (d_wmask == 4'b0000);
            last_d_d  = 1'b1;
        end
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        rv_i_d      = i_win;
        rv_d_d      = d_win;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_d_q    <= 1'b1;
            rv_i_q      <= 1'b0;
            rv_d_q      <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            last_d_q    <= last_d_d;
            rv_i_q      <= rv_i_d;
            rv_d_q      <= rv_d_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign i_gnt    = i_win;
    assign d_gnt    = d_win;
    assign i_rvalid = rv_i_q;
    assign d_rvalid = rv_d_q;
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule
